// File: rtl/mmio_spi_core_if.sv
// MMIO slot bus bundle for mmio_spi_core.
// Ports: cs/read/write/addr/wr_data from controller, rd_data back.
interface mmio_spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mmio_spi_core.sv
// Single-slot SPI master: one byte per transfer, full duplex.
// Ports: clk, reset_n, bus (slot slave), spi_sclk/mosi/miso, spi_ss_n[S].
// Option: define SPI_LOOPBACK_EN for CTRL[18] mosi->rx loopback.
module mmio_spi_core #(
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  mmio_spi_core_if.slave bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  typedef enum logic [1:0] {
    IDLE, CPHA_DLY, P0, P1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rxb_q, rxb_d;
  logic [15:0] dvsr_q;
  logic        cpol_q, cpha_q;
  logic        sclk_q, sclk_d;
  logic [S-1:0] ss_q;
  logic        ready;
  logic        wr_en;
  logic        done;
  logic        miso_s;
  logic        unused;

  assign wr_en = bus.cs && bus.write;
  assign ready = (state_q == IDLE);
  assign done  = (cnt_q == dvsr_q);

  assign unused = ^{bus.read, bus.wr_data};

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  assign miso_s = lb_q ? tx_q[7] : spi_miso;
`else
  assign miso_s = spi_miso;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxb_d   = rxb_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en && bus.addr == 5'd2) begin
          tx_d    = bus.wr_data[7:0];
          bit_d   = 3'd0;
          cnt_d   = 16'd0;
          state_d = cpha_q ? CPHA_DLY : P0;
        end
      end
      CPHA_DLY: begin
        if (done) begin
          cnt_d   = 16'd0;
          state_d = P0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      P0: begin
        if (done) begin
          rx_d    = {rx_q[6:0], miso_s};
          cnt_d   = 16'd0;
          state_d = P1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      P1: begin
        if (done) begin
          cnt_d = 16'd0;
          if (bit_q == 3'd7) begin
            rxb_d   = rx_q;
            state_d = IDLE;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = P0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sclk follows the next state so it changes with the phase boundary
  always_comb begin
    sclk_d = cpol_q ^ (((state_d == P1) && !cpha_q) ||
                       ((state_d == P0) && cpha_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rxb_q   <= 8'd0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxb_q   <= rxb_d;
      sclk_q  <= sclk_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_q   <= '1;
      dvsr_q <= 16'h0200;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      if (wr_en && bus.addr == 5'd1)
        ss_q <= bus.wr_data[S-1:0];
      if (wr_en && bus.addr == 5'd3 && ready) begin
        dvsr_q <= bus.wr_data[15:0];
        cpol_q <= bus.wr_data[16];
        cpha_q <= bus.wr_data[17];
      end
    end
  end

`ifdef SPI_LOOPBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lb_q <= 1'b0;
    else if (wr_en && bus.addr == 5'd3 && ready)
      lb_q <= bus.wr_data[18];
  end
`endif

  always_comb begin
    bus.rd_data = 32'd0;
    if (bus.addr == 5'd0)
      bus.rd_data = {23'd0, ready, rxb_q};
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = tx_q[7];
  assign spi_ss_n = ss_q;

endmodule

// File: tb/tb_mmio_spi_core.sv
// Self-checking bench for mmio_spi_core with a behavioural SPI slave.
// Ports: drives bus interface, clk/reset_n, observes SPI pins.
module tb_mmio_spi_core;
  localparam int S = 2;
  localparam int N = 1024;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [S-1:0] spi_ss_n;

  mmio_spi_core_if bus();

  mmio_spi_core #(.S(S)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bench-side view of the configured mode
  int   m_dvsr = 512;
  bit   m_cpol = 0;
  bit   m_cpha = 0;

  // slave model state
  bit        slv_en = 0;
  logic [7:0] slv_tx = 8'h00;
  logic      miso_hold = 1'b0;
  int        rise_cnt = 0;
  int        fall_cnt = 0;
  int        r0 = 0;
  int        f0 = 0;
  logic      rise_mosi [N];
  logic      fall_mosi [N];
  longint    rise_t [N];
  longint    fall_t [N];
  int        tx_cyc;
  longint    tx_t;

  always @(spi_sclk) begin
    if (spi_sclk === 1'b1) begin
      rise_cnt = rise_cnt + 1;
      rise_mosi[rise_cnt % N] = spi_mosi;
      rise_t[rise_cnt % N] = $time;
    end else if (spi_sclk === 1'b0) begin
      fall_cnt = fall_cnt + 1;
      fall_mosi[fall_cnt % N] = spi_mosi;
      fall_t[fall_cnt % N] = $time;
    end
  end

  // slave output bit: count edges on which a slave of this mode shifts
  always_comb begin
    int ch;
    int idx;
    ch = (m_cpol == m_cpha) ? fall_cnt - f0 : rise_cnt - r0;
    idx = m_cpha ? ch - 1 : ch;
    if (idx < 0) idx = 0;
    if (idx > 7) idx = 7;
    spi_miso = slv_en ? slv_tx[7 - idx] : miso_hold;
  end

  initial begin
    bus.cs = 0;
    bus.read = 0;
    bus.write = 0;
    bus.addr = 0;
    bus.wr_data = 0;
  end

  // call just after a negedge; the write lands on the next posedge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1;
    bus.write = 1;
    bus.addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.cs = 0;
    bus.write = 0;
    bus.addr = 0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_ctrl(input int d, input bit pol, input bit pha);
    bus_write(5'd3, {14'd0, pha, pol, d[15:0]});
    m_dvsr = d;
    m_cpol = pol;
    m_cpha = pha;
    idle(2);
  endtask

  task automatic start_xfer(input logic [7:0] mtx, input logic [7:0] stx);
    slv_tx = stx;
    r0 = rise_cnt;
    f0 = fall_cnt;
    slv_en = 1;
    bus_write(5'd2, {24'd0, mtx});
    tx_cyc = cyc;
    tx_t = $time - 6;
  endtask

  task automatic finish_xfer(output int busy, output logic [31:0] st,
                             output logic [7:0] srx);
    int lim;
    lim = 20 * (m_dvsr + 1) + 40;
    busy = -1;
    for (int i = 0; i < lim; i++) begin
      if (bus.rd_data[8] === 1'b1) begin
        busy = cyc - tx_cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    st = bus.rd_data;
    srx = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (m_cpol == m_cpha)
        srx = {srx[6:0], rise_mosi[(r0 + 1 + k) % N]};
      else
        srx = {srx[6:0], fall_mosi[(f0 + 1 + k) % N]};
    end
    slv_en = 0;
    idle(1);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.rd_data !== 32'h0000_0100) begin
      failures++;
      $display("FAIL reset_status got=%h want=%h", bus.rd_data, 32'h100);
    end
    checks++;
    if (spi_ss_n !== 2'b11) begin
      failures++;
      $display("FAIL reset_ss got=%b want=11", spi_ss_n);
    end
    checks++;
    if ({spi_sclk, spi_mosi} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pins sclk/mosi got=%b want=00",
               {spi_sclk, spi_mosi});
    end
  endtask

  task automatic test_mode0;
    int busy;
    logic [31:0] st;
    logic [7:0] srx;
    bit sp_ok;
    longint dt;
    set_ctrl(3, 0, 0);
    start_xfer(8'hA5, 8'h3C);
    finish_xfer(busy, st, srx);
    checks++;
    if (busy != 64) begin
      failures++;
      $display("FAIL mode0_busy got=%0d want=64", busy);
    end
    checks++;
    if (st !== 32'h0000_013C) begin
      failures++;
      $display("FAIL mode0_status got=%h want=0000013c", st);
    end
    checks++;
    if (srx !== 8'hA5) begin
      failures++;
      $display("FAIL mode0_mosi got=%h want=a5", srx);
    end
    checks++;
    if (rise_cnt - r0 != 8) begin
      failures++;
      $display("FAIL mode0_edges got=%0d want=8", rise_cnt - r0);
    end
    sp_ok = 1;
    dt = 0;
    for (int k = 1; k < 8; k++) begin
      dt = rise_t[(r0 + k + 1) % N] - rise_t[(r0 + k) % N];
      if (dt != 80) begin
        sp_ok = 0;
        break;
      end
    end
    checks++;
    if (!sp_ok) begin
      failures++;
      $display("FAIL mode0_spacing got=%0d want=80 ns", dt);
    end
  endtask

  task automatic test_mode3;
    int busy;
    logic [31:0] st;
    logic [7:0] srx;
    logic [7:0] stx;
    longint dt;
    set_ctrl(0, 1, 1);
    checks++;
    if (spi_sclk !== 1'b1) begin
      failures++;
      $display("FAIL mode3_idle got=%b want=1", spi_sclk);
    end
    stx = 8'($urandom);
    start_xfer(8'h81, stx);
    finish_xfer(busy, st, srx);
    dt = fall_t[(f0 + 1) % N] - tx_t;
    checks++;
    if (dt != 10) begin
      failures++;
      $display("FAIL mode3_first_edge got=%0d want=10 ns", dt);
    end
    checks++;
    if (busy != 17) begin
      failures++;
      $display("FAIL mode3_busy got=%0d want=17", busy);
    end
    checks++;
    if (srx !== 8'h81) begin
      failures++;
      $display("FAIL mode3_slave_rx got=%h want=81", srx);
    end
    checks++;
    if (st !== {23'd0, 1'b1, stx}) begin
      failures++;
      $display("FAIL mode3_status got=%h want=%h", st, {23'd0, 1'b1, stx});
    end
  endtask

  task automatic test_random_modes;
    int busy;
    int exp_busy;
    logic [31:0] st;
    logic [7:0] srx;
    logic [7:0] mtx;
    logic [7:0] stx;
    for (int it = 0; it < 10; it++) begin
      set_ctrl($urandom_range(0, 4), 1'($urandom), 1'($urandom));
      mtx = 8'($urandom);
      stx = 8'($urandom);
      exp_busy = (m_cpha ? 17 : 16) * (m_dvsr + 1);
      start_xfer(mtx, stx);
      finish_xfer(busy, st, srx);
      checks++;
      if (busy != exp_busy) begin
        failures++;
        $display("FAIL rand%0d_busy got=%0d want=%0d", it, busy, exp_busy);
      end
      checks++;
      if (st !== {23'd0, 1'b1, stx}) begin
        failures++;
        $display("FAIL rand%0d_status got=%h want=%h", it, st,
                 {23'd0, 1'b1, stx});
      end
      checks++;
      if (srx !== mtx) begin
        failures++;
        $display("FAIL rand%0d_slave_rx got=%h want=%h", it, srx, mtx);
      end
      checks++;
      if (spi_sclk !== m_cpol) begin
        failures++;
        $display("FAIL rand%0d_sclk_idle got=%b want=%b", it, spi_sclk,
                 m_cpol);
      end
    end
  endtask

  task automatic test_busy_reject;
    int busy;
    logic [31:0] st;
    logic [7:0] srx;
    logic [7:0] stx;
    set_ctrl(1, 0, 0);
    stx = 8'($urandom);
    start_xfer(8'h11, stx);
    idle(3);
    bus_write(5'd2, 32'h22);
    bus_write(5'd3, 32'h5);
    finish_xfer(busy, st, srx);
    checks++;
    if (busy != 32) begin
      failures++;
      $display("FAIL reject_busy got=%0d want=32", busy);
    end
    checks++;
    if (srx !== 8'h11) begin
      failures++;
      $display("FAIL reject_slave_rx got=%h want=11", srx);
    end
    start_xfer(8'h3E, stx);
    finish_xfer(busy, st, srx);
    checks++;
    if (busy != 32) begin
      failures++;
      $display("FAIL reject_dvsr_kept got=%0d want=32", busy);
    end
    checks++;
    if (rise_cnt - r0 != 8) begin
      failures++;
      $display("FAIL reject_edges got=%0d want=8", rise_cnt - r0);
    end
  endtask

  task automatic test_tx_at_done;
    int nb;
    int rc;
    logic [7:0] stx;
    set_ctrl(2, 0, 0);
    nb = 48;
    stx = 8'($urandom);
    start_xfer(8'hC6, stx);
    for (int i = 0; i < 200 && cyc < tx_cyc + nb - 1; i++)
      @(negedge clk);
    #1;
    checks++;
    if (bus.rd_data[8] !== 1'b0) begin
      failures++;
      $display("FAIL done_edge_ready_before got=%b want=0", bus.rd_data[8]);
    end
    bus_write(5'd2, 32'hFF);
    rc = rise_cnt;
    idle(6);
    checks++;
    if (bus.rd_data !== {23'd0, 1'b1, stx}) begin
      failures++;
      $display("FAIL done_edge_status got=%h want=%h", bus.rd_data,
               {23'd0, 1'b1, stx});
    end
    checks++;
    if (rise_cnt != rc) begin
      failures++;
      $display("FAIL done_edge_ignored edges got=%0d want=0", rise_cnt - rc);
    end
    slv_en = 0;
  endtask

  task automatic test_ss;
    int rc;
    int fc;
    rc = rise_cnt;
    fc = fall_cnt;
    bus_write(5'd1, 32'h2);
    idle(20);
    checks++;
    if (spi_ss_n !== 2'b10) begin
      failures++;
      $display("FAIL ss_write got=%b want=10", spi_ss_n);
    end
    checks++;
    if (rise_cnt != rc || fall_cnt != fc) begin
      failures++;
      $display("FAIL ss_no_sclk edges got=%0d want=0",
               (rise_cnt - rc) + (fall_cnt - fc));
    end
  endtask

  task automatic test_loopback;
    logic [31:0] st;
    logic [31:0] exp;
    miso_hold = 1'b0;
    bus_write(5'd3, 32'h0004_0001);
    m_dvsr = 1;
    m_cpol = 0;
    m_cpha = 0;
    idle(2);
    bus_write(5'd2, 32'h5A);
    idle(40);
    st = bus.rd_data;
`ifdef SPI_LOOPBACK_EN
    exp = 32'h0000_015A;
`else
    exp = 32'h0000_0100;
`endif
    checks++;
    if (st !== exp) begin
      failures++;
      $display("FAIL loopback_status got=%h want=%h", st, exp);
    end
  endtask

  task automatic test_reset_mid;
    int busy;
    logic [31:0] st;
    logic [7:0] srx;
    set_ctrl(3, 0, 0);
    start_xfer(8'h00, 8'hC3);
    finish_xfer(busy, st, srx);
    bus_write(5'd1, 32'h1);
    start_xfer(8'h77, 8'h99);
    idle(10);
    slv_en = 0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0000_0100) begin
      failures++;
      $display("FAIL midreset_status got=%h want=00000100", bus.rd_data);
    end
    checks++;
    if (spi_ss_n !== 2'b11) begin
      failures++;
      $display("FAIL midreset_ss got=%b want=11", spi_ss_n);
    end
    checks++;
    if (spi_sclk !== 1'b0) begin
      failures++;
      $display("FAIL midreset_sclk got=%b want=0", spi_sclk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    test_reset;
    test_mode0;
    test_mode3;
    test_random_modes;
    test_busy_reject;
    test_tx_at_done;
    test_ss;
    test_loopback;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
